wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Registered writeback stage for the 5-stage core; successor to the combinational pass-through.
//   Accepts retiring instructions from the mem stage over a valid/ready handshake.
//   Writes ALU results after one cycle. Holds a load until memory read data returns, then aligns and extends it.
//   Forwards jump requests to the fetch stage. Supports flush and a load-response timeout.
// PARAMETERS
//   XLEN     32  data/address width
//   REG_AW   5   register-file address width
//   TIMEOUT  16  max cycles in WAIT_LOAD before abort; 0 = never abort
// PORTS
//   clk            in   1       clock, all logic on rising edge
//   rst            in   1       synchronous reset, active-high
//   in_valid_i     in   1       mem stage presents an instruction
//   in_ready_o     out  1       stage can accept (comb: state==IDLE)
//   reg_we_i       in   1       instruction writes a GPR
//   reg_waddr_i    in   REG_AW  destination GPR
//   reg_wdata_i    in   XLEN    ALU result (ignored for loads)
//   jump_flag_i    in   1       jump request (ignored for loads)
//   jump_addr_i    in   XLEN    jump target
//   load_i         in   1       instruction is a load
//   load_funct3_i  in   3       000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   load_offs_i    in   2       byte address bits [1:0] of load
//   mem_rvalid_i   in   1       read data valid (one-cycle pulse)
//   mem_rdata_i    in   XLEN    aligned word read from memory
//   flush_i        in   1       discard accepted/pending work
//   reg_we_o       out  1       regfile write strobe (one-cycle pulse)
//   reg_waddr_o    out  REG_AW  regfile write address
//   reg_wdata_o    out  XLEN    regfile write data
//   jump_flag_o    out  1       jump strobe (one-cycle pulse)
//   jump_addr_o    out  XLEN    jump target
//   busy_o         out  1       state==WAIT_LOAD
//   timeout_o      out  1       sticky: a load timed out
// BEHAVIOUR
//   Reset: state IDLE, counter 0, all outputs 0 (timeout_o 0, in_ready_o 1).
//     Reset during WAIT_LOAD discards the load.
//   Acceptance: cycle N where in_valid_i & in_ready_o & !flush_i.
//   States: IDLE, WAIT_LOAD.
//     IDLE -> WAIT_LOAD when a load is accepted.
//     WAIT_LOAD -> IDLE on mem_rvalid_i, timeout or flush_i.
//   Non-load accepted in N (state stays IDLE, back-to-back accepts allowed):
//     At N+1: reg_we_o = reg_we_i & (reg_waddr_i!=0), reg_waddr_o/reg_wdata_o = inputs.
//     At N+1: jump_flag_o = jump_flag_i, jump_addr_o = jump_addr_i.
//   Load accepted in N: latch waddr, we, funct3, offs; go WAIT_LOAD; in_ready_o=0 from N+1.
//   mem_rvalid_i in WAIT_LOAD at cycle M:
//     M+1: reg_we_o = latched we & waddr!=0, wdata = extracted value; state IDLE, in_ready_o=1.
//   Extraction:
//     byte = rdata[8*offs +: 8].
//     half = rdata[16*offs[1] +: 16] (offs[0] ignored).
//     LB/LH sign-extend; LBU/LHU zero-extend; LW and undefined funct3 pass the full word.
//   mem_rvalid_i while IDLE: ignored.
//   Timeout (TIMEOUT>0): counter clears on entering WAIT_LOAD and increments each WAIT_LOAD cycle without rvalid.
//     Reaching TIMEOUT: IDLE next cycle, no write, timeout_o set (held until rst).
//     rvalid in the same cycle as the limit wins (write happens).
//   flush_i: highest priority below rst.
//     Blocks acceptance in its cycle.
//     Aborts WAIT_LOAD (IDLE next cycle, no write, even with simultaneous rvalid).
//     Forces reg_we_o=0 and jump_flag_o=0 in the next cycle.
//   reg_waddr_o/reg_wdata_o/jump_addr_o hold their last value when strobes are low.
//   x0 never written; reg_we_o never high two cycles from one instruction.
// TESTING
//   ALU accept x5=0x1234 in N -> reg_we_o=1, waddr=5, wdata=0x1234 at N+1 only; in_ready_o stays 1.
//   Jump 0x80 accepted with reg_we_i=1, waddr=0 -> jump_flag_o=1, jump_addr_o=0x80 at N+1; reg_we_o=0.
//   LB offs=3, rdata=0x80FF_0000 after 4 cycles -> wdata=0xFFFF_FF80 at rvalid+1; in_ready_o low during wait.
//     Same with LHU offs=2 -> 0x0000_80FF.
//   Load with no rvalid, TIMEOUT=16 -> 16 wait cycles, IDLE, timeout_o=1 sticky, no reg_we_o.
//     Later rvalid is ignored.
//   flush_i together with rvalid in WAIT_LOAD -> no write, IDLE next cycle.
//     flush_i with in_valid_i -> no accept, no pulse.
//   rst asserted mid WAIT_LOAD -> all outputs 0 next cycle; subsequent ALU accept writes normally.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered writeback stage with load wait, timeout and flush
module wb_stage #(
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              reg_we_i,
   input  logic [REG_AW-1:0] reg_waddr_i,
   input  logic [XLEN-1:0]   reg_wdata_i,
   input  logic              jump_flag_i,
   input  logic [XLEN-1:0]   jump_addr_i,
   input  logic              load_i,
   input  logic [2:0]        load_funct3_i,
   input  logic [1:0]        load_offs_i,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              flush_i,
   output logic              reg_we_o,
   output logic [REG_AW-1:0] reg_waddr_o,
   output logic [XLEN-1:0]   reg_wdata_o,
   output logic              jump_flag_o,
   output logic [XLEN-1:0]   jump_addr_o,
   output logic              busy_o,
   output logic              timeout_o
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   // Counter only needs to reach TIMEOUT-1: the abort fires in the last allowed wait cycle
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              ld_we;
   logic [REG_AW-1:0] ld_waddr;
   logic [2:0]        ld_funct3;
   logic [1:0]        ld_offs;

   logic accept;
   logic at_limit;
   logic rvalid_hit;
   logic tmo_hit;

   function automatic logic [XLEN-1:0] extract(input logic [2:0]      funct3,
                                               input logic [1:0]      offs,
                                               input logic [XLEN-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{offs, 3'b000} +: 8];
      h = word[{offs[1], 4'b0000} +: 16];
      case (funct3)
         3'b000:  extract = {{(XLEN-8){b[7]}}, b};
         3'b001:  extract = {{(XLEN-16){h[15]}}, h};
         3'b100:  extract = {{(XLEN-8){1'b0}}, b};
         3'b101:  extract = {{(XLEN-16){1'b0}}, h};
         default: extract = word;
      endcase
   endfunction

   assign in_ready_o = (state == IDLE);
   assign busy_o     = (state == WAIT_LOAD);
   assign accept     = in_valid_i & in_ready_o & ~flush_i;
   assign at_limit   = (TIMEOUT > 0) && (int'(cnt) == TIMEOUT - 1);
   assign rvalid_hit = busy_o & mem_rvalid_i & ~flush_i;
   assign tmo_hit    = busy_o & ~mem_rvalid_i & ~flush_i & at_limit;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept && load_i) state_nxt = WAIT_LOAD;
         WAIT_LOAD: if (flush_i || mem_rvalid_i || tmo_hit) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ld_we       <= 1'b0;
         ld_waddr    <= '0;
         ld_funct3   <= '0;
         ld_offs     <= '0;
         reg_we_o    <= 1'b0;
         reg_waddr_o <= '0;
         reg_wdata_o <= '0;
         jump_flag_o <= 1'b0;
         jump_addr_o <= '0;
         timeout_o   <= 1'b0;
      end else begin
         state       <= state_nxt;
         reg_we_o    <= 1'b0;
         jump_flag_o <= 1'b0;

         if (accept && !load_i) begin
            if (reg_we_i && (reg_waddr_i != '0)) begin
               reg_we_o    <= 1'b1;
               reg_waddr_o <= reg_waddr_i;
               reg_wdata_o <= reg_wdata_i;
            end
            if (jump_flag_i) begin
               jump_flag_o <= 1'b1;
               jump_addr_o <= jump_addr_i;
            end
         end

         if (accept && load_i) begin
            ld_we     <= reg_we_i;
            ld_waddr  <= reg_waddr_i;
            ld_funct3 <= load_funct3_i;
            ld_offs   <= load_offs_i;
            cnt       <= '0;
         end else if (busy_o && !mem_rvalid_i && (TIMEOUT > 0)) begin
            cnt <= cnt + CW'(1);
         end

         // Destination register 0 is a sink: the load still completes, nothing is written
         if (rvalid_hit && ld_we && (ld_waddr != '0)) begin
            reg_we_o    <= 1'b1;
            reg_waddr_o <= ld_waddr;
            reg_wdata_o <= extract(ld_funct3, ld_offs, mem_rdata_i);
         end

         if (tmo_hit) timeout_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic        reg_we_i;
   logic [4:0]  reg_waddr_i;
   logic [31:0] reg_wdata_i;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        load_i;
   logic [2:0]  load_funct3_i;
   logic [1:0]  load_offs_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        flush_i;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        busy_o;
   logic        timeout_o;

   int vecs = 0;
   int errs = 0;
   int busy_cycles;
   int stray_we;

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32), .REG_AW(5), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
      .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .load_i(load_i), .load_funct3_i(load_funct3_i), .load_offs_i(load_offs_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .flush_i(flush_i),
      .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
      .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic jf, input logic [31:0] ja, input logic ld,
                        input logic [2:0] f3, input logic [1:0] offs);
      in_valid_i = v; reg_we_i = we; reg_waddr_i = wa; reg_wdata_i = wd;
      jump_flag_i = jf; jump_addr_i = ja; load_i = ld; load_funct3_i = f3; load_offs_i = offs;
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();

      // reset state
      chk("rst_in_ready", 32'(in_ready_o), 1);
      chk("rst_reg_we", 32'(reg_we_o), 0);
      chk("rst_waddr", 32'(reg_waddr_o), 0);
      chk("rst_wdata", reg_wdata_o, 0);
      chk("rst_jump", 32'(jump_flag_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_timeout", 32'(timeout_o), 0);
      rst = 1'b0;

      // ALU write x5 = 0x1234
      drive(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
      tick();
      chk("alu_we", 32'(reg_we_o), 1);
      chk("alu_waddr", 32'(reg_waddr_o), 5);
      chk("alu_wdata", reg_wdata_o, 32'h1234);
      chk("alu_ready", 32'(in_ready_o), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("alu_we_pulse", 32'(reg_we_o), 0);
      chk("alu_wdata_hold", reg_wdata_o, 32'h1234);

      // jump with rd = x0
      drive(1, 1, 0, 32'hDEAD, 1, 32'h80, 0, 0, 0);
      tick();
      chk("jmp_flag", 32'(jump_flag_o), 1);
      chk("jmp_addr", jump_addr_o, 32'h80);
      chk("jmp_x0_we", 32'(reg_we_o), 0);
      chk("jmp_waddr_hold", 32'(reg_waddr_o), 5);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("jmp_pulse", 32'(jump_flag_o), 0);

      // LB offs=3, jump request on the load is ignored
      drive(1, 1, 7, 32'hFFFF, 1, 32'h44, 1, 3'b000, 2'd3);
      tick();
      chk("lb_ready_low", 32'(in_ready_o), 0);
      chk("lb_busy", 32'(busy_o), 1);
      chk("lb_no_jump", 32'(jump_flag_o), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_0000;
      chk("lb_wait_we", 32'(reg_we_o), 0);
      tick();
      mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      chk("lb_we", 32'(reg_we_o), 1);
      chk("lb_waddr", 32'(reg_waddr_o), 7);
      chk("lb_wdata", reg_wdata_o, 32'hFFFF_FF80);
      chk("lb_ready", 32'(in_ready_o), 1);
      tick();
      chk("lb_we_pulse", 32'(reg_we_o), 0);

      // LHU offs=2
      drive(1, 1, 8, 0, 0, 0, 1, 3'b101, 2'd2);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_0000;
      tick();
      mem_rvalid_i = 1'b0;
      chk("lhu_we", 32'(reg_we_o), 1);
      chk("lhu_wdata", reg_wdata_o, 32'h0000_80FF);

      // LH offs=1 (low half, offs[0] ignored), data in first wait cycle
      drive(1, 1, 9, 0, 0, 0, 1, 3'b001, 2'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_8001;
      tick();
      mem_rvalid_i = 1'b0;
      chk("lh_wdata", reg_wdata_o, 32'hFFFF_8001);

      // LW to x0: completes, no write
      drive(1, 1, 0, 0, 0, 0, 1, 3'b010, 2'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
      tick();
      mem_rvalid_i = 1'b0;
      chk("lw_x0_we", 32'(reg_we_o), 0);
      chk("lw_x0_idle", 32'(in_ready_o), 1);

      // timeout: no rvalid
      drive(1, 1, 10, 0, 0, 0, 1, 3'b010, 2'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      busy_cycles = 0; stray_we = 0;
      while (busy_o && busy_cycles < 40) begin
         busy_cycles++;
         if (reg_we_o) stray_we++;
         tick();
      end
      chk("tmo_cycles", busy_cycles, 16);
      chk("tmo_no_write", stray_we + 32'(reg_we_o), 0);
      chk("tmo_flag", 32'(timeout_o), 1);
      chk("tmo_ready", 32'(in_ready_o), 1);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
      tick();
      mem_rvalid_i = 1'b0;
      chk("tmo_late_rvalid", 32'(reg_we_o), 0);
      chk("tmo_sticky", 32'(timeout_o), 1);

      // flush with rvalid during wait
      drive(1, 1, 11, 0, 0, 0, 1, 3'b010, 2'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fl_busy", 32'(busy_o), 1);
      mem_rvalid_i = 1'b1; flush_i = 1'b1; mem_rdata_i = 32'h2222_2222;
      tick();
      mem_rvalid_i = 1'b0; flush_i = 1'b0;
      chk("fl_rv_we", 32'(reg_we_o), 0);
      chk("fl_rv_idle", 32'(busy_o), 0);

      // flush with in_valid
      drive(1, 1, 3, 32'h55, 1, 32'h90, 0, 0, 0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fl_in_we", 32'(reg_we_o), 0);
      chk("fl_in_jump", 32'(jump_flag_o), 0);
      chk("fl_in_wdata_hold", reg_wdata_o, 32'hFFFF_8001);

      // reset mid wait
      drive(1, 1, 12, 0, 0, 0, 1, 3'b010, 2'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_ready", 32'(in_ready_o), 1);
      chk("mrst_timeout", 32'(timeout_o), 0);
      chk("mrst_wdata", reg_wdata_o, 0);
      chk("mrst_jaddr", jump_addr_o, 0);
      drive(1, 1, 10, 32'hCAFE, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mrst_alu_we", 32'(reg_we_o), 1);
      chk("mrst_alu_wdata", reg_wdata_o, 32'hCAFE);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
